mult35x35_parallel_pipe: RTL and testbench

Unsigned 35x35-bit multiplier that returns a 70-bit product. It is fully pipelined: one new operand pair is accepted every clock and each result appears a fixed number of cycles later. The product is built in parallel from 18-bit/17-bit partial products, then passed through a registered adder tree. It is a standalone datapath block with no handshake; the consumer samples PROD_OUT a known latency after driving the operands.

---
 rtl/mult_pkg.sv | 12 +
 rtl/mult_pp_18x18.sv | 28 ++
 rtl/mult35x35_parallel_pipe.sv | 77 +++++++
 tb/tb_mult35x35_parallel_pipe.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths and types for the 35x35 pipelined multiplier.
// The operand is split into an 18-bit low slice and a 17-bit high slice.
package mult_pkg;
    localparam int W       = 35;
    localparam int PW      = 70;
    localparam int LO_W    = 18;
    localparam int HI_W    = 17;
    localparam int LATENCY = 4;

    typedef logic [W-1:0]  operand_t;
    typedef logic [PW-1:0] product_t;
endpackage

// File: rtl/mult_pp_18x18.sv
// Unsigned 18x18 partial-product multiplier with one output register stage.
// High slices arrive zero-extended, so the product is treated as unsigned.
module mult_pp_18x18
    import mult_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [LO_W-1:0]     a_in,
    input  logic [LO_W-1:0]     b_in,
    output logic [2*LO_W-1:0]   prod_out
);
    logic [2*LO_W-1:0] prod_d;
    logic [2*LO_W-1:0] prod_q;

    always_comb begin
        prod_d = {{LO_W{1'b0}}, a_in} * {{LO_W{1'b0}}, b_in};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign prod_out = prod_q;
endmodule

// File: rtl/mult35x35_parallel_pipe.sv
// Four-stage unsigned 35x35 multiplier: input register, four parallel
// partial products, middle-term add, then the final shifted sum.
module mult35x35_parallel_pipe
    import mult_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  operand_t A_IN,
    input  operand_t B_IN,
    output product_t PROD_OUT
);
    // S1: operand capture
    operand_t a_d, a_q;
    operand_t b_d, b_q;

    // S2: partial products, registered inside the sub-modules
    logic [LO_W-1:0]   a_lo, a_hi, b_lo, b_hi;
    logic [2*LO_W-1:0] pll, plh, phl, phh;

    // S3: middle term plus forwarded outer terms
    logic [2*LO_W-1:0] mid_d, mid_q;
    logic [2*LO_W-1:0] pll_d, pll_q;
    logic [2*LO_W-1:0] phh_d, phh_q;

    // S4: final product
    product_t prod_d, prod_q;

    always_comb begin
        a_d = A_IN;
        b_d = B_IN;
    end

    always_comb begin
        a_lo = a_q[LO_W-1:0];
        b_lo = b_q[LO_W-1:0];
        a_hi = {1'b0, a_q[W-1:LO_W]};
        b_hi = {1'b0, b_q[W-1:LO_W]};
    end

    mult_pp_18x18 u_pp_ll (.CLK(CLK), .RST(RST), .a_in(a_lo), .b_in(b_lo), .prod_out(pll));
    mult_pp_18x18 u_pp_lh (.CLK(CLK), .RST(RST), .a_in(a_lo), .b_in(b_hi), .prod_out(plh));
    mult_pp_18x18 u_pp_hl (.CLK(CLK), .RST(RST), .a_in(a_hi), .b_in(b_lo), .prod_out(phl));
    mult_pp_18x18 u_pp_hh (.CLK(CLK), .RST(RST), .a_in(a_hi), .b_in(b_hi), .prod_out(phh));

    // Both cross terms are below 2^35, so their 36-bit sum cannot overflow.
    always_comb begin
        mid_d = plh + phl;
        pll_d = pll;
        phh_d = phh;
    end

    always_comb begin
        prod_d = (product_t'(phh_q) << (2*LO_W))
               + (product_t'(mid_q) << LO_W)
               + product_t'(pll_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q    <= '0;
            b_q    <= '0;
            mid_q  <= '0;
            pll_q  <= '0;
            phh_q  <= '0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            mid_q  <= mid_d;
            pll_q  <= pll_d;
            phh_q  <= phh_d;
            prod_q <= prod_d;
        end
    end

    assign PROD_OUT = prod_q;
endmodule

// File: tb/tb_mult35x35_parallel_pipe.sv
// Directed and streamed checks of the 35x35 multiplier: each operand pair
// driven in a cycle must show its product on PROD_OUT LATENCY edges later.
module tb_mult35x35_parallel_pipe;
    import mult_pkg::*;

    logic     CLK = 1'b0;
    logic     RST;
    operand_t A_IN;
    operand_t B_IN;
    product_t PROD_OUT;

    int       n_checks = 0;
    int       n_errors = 0;
    product_t exp_q[$];
    string    tag_q[$];

    mult35x35_parallel_pipe dut (
        .CLK      (CLK),
        .RST      (RST),
        .A_IN     (A_IN),
        .B_IN     (B_IN),
        .PROD_OUT (PROD_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input product_t got, input product_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive one pair for one cycle; the entry LATENCY pushes older is due now.
    task automatic push_pair(input string tag, input operand_t a, input operand_t b,
                             input product_t exp);
        A_IN = a;
        B_IN = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        step();
        check_val(tag_q.pop_front(), PROD_OUT, exp_q.pop_front());
    endtask

    // After reset the pipeline holds zeros for LATENCY-1 more edges.
    task automatic prime();
        exp_q.delete();
        tag_q.delete();
        for (int i = 0; i < LATENCY - 1; i++) begin
            exp_q.push_back('0);
            tag_q.push_back("post_rst_zero");
        end
    endtask

    task automatic flush();
        for (int i = 0; i < LATENCY; i++) push_pair("flush_zero", '0, '0, '0);
    endtask

    operand_t va[9];
    operand_t vb[9];
    product_t vp[9];
    string    vt[9];

    initial begin
        operand_t ra, rb;

        va = '{35'd1, 35'h7_FFFF_FFFF, 35'h4_0000_0000, 35'h4_0000, 35'h3_FFFF,
               35'd0, 35'd12345678901, 35'h7_FFFF_FFFF, 35'd123456789};
        vb = '{35'd1, 35'h7_FFFF_FFFF, 35'h4_0000_0000, 35'h2_0000, 35'h3_FFFF,
               35'h7_FFFF_FFFF, 35'd1, 35'd1, 35'd987654321};
        vp = '{70'd1, 70'd1180591620648691826689, 70'd295147905179352825856,
               70'd34359738368, 70'd68718952449, 70'd0, 70'd12345678901,
               70'd34359738367, 70'd121932631112635269};
        vt = '{"unit", "max", "hi_hi_2p68", "lo_hi_2p35", "lo_lo_max",
               "zero", "a_times_one", "max_times_one", "decimal_pair"};

        // Reset with live operands: they must never surface.
        RST  = 1'b1;
        A_IN = 35'd5;
        B_IN = 35'd7;
        step();
        check_val("reset_edge1", PROD_OUT, '0);
        step();
        check_val("reset_edge2", PROD_OUT, '0);
        RST = 1'b0;
        prime();

        for (int i = 0; i < 9; i++) push_pair(vt[i], va[i], vb[i], vp[i]);
        flush();

        for (int i = 0; i < 20; i++) begin
            ra = {3'($urandom_range(7, 0)), 32'($urandom)};
            rb = {3'($urandom_range(7, 0)), 32'($urandom)};
            push_pair("stream", ra, rb, product_t'(ra) * product_t'(rb));
        end

        for (int i = 0; i < 17; i++)
            push_pair("steady", 35'd123456789, 35'd987654321, 70'd121932631112635269);
        flush();

        // Mid-stream reset: three pairs in flight are lost.
        push_pair("pre_rst_zero", 35'd1000, 35'd1000, 70'd1000000);
        push_pair("pre_rst_zero", 35'd2000, 35'd2000, 70'd4000000);
        push_pair("pre_rst_zero", 35'd3000, 35'd3000, 70'd9000000);
        RST  = 1'b1;
        A_IN = 35'd9;
        B_IN = 35'd9;
        step();
        check_val("mid_reset", PROD_OUT, '0);
        RST = 1'b0;
        prime();
        push_pair("three_times_four", 35'd3, 35'd4, 70'd12);
        flush();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
